// File: rtl/cache_controller.sv
// Load/store front end for a 2-way data cache backed by a line-wide SRAM controller.
// Hits return in the same cycle; misses fill a 64-bit line; stores are write-through, no-allocate.
module cache_controller #(
    parameter int BASE_ADDR = 1024,
    parameter int PERF_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [31:0]       address,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic [16:0]       cache_address,
    output logic [63:0]       cache_write_data,
    output logic              cache_read_en,
    output logic              cache_write_en,
    output logic              cache_inv_en,
    input  logic [31:0]       cache_read_data,
    input  logic              cache_hit,
    output logic              sram_r_en,
    output logic              sram_w_en,
    output logic [31:0]       sram_address,
    output logic [31:0]       sram_wdata,
    input  logic [63:0]       sram_rdata,
    input  logic              sram_ready,
    output logic [PERF_W-1:0] hit_count,
    output logic [PERF_W-1:0] miss_count
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_MISS = 2'd1;
    localparam logic [1:0] WR      = 2'd2;

    logic [1:0]  state;
    logic [31:0] offs;
    logic [31:0] line_addr;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        word_sel;
    logic        unused_offs;

    assign offs          = address - 32'(BASE_ADDR);
    assign cache_address = offs[18:2];
    assign unused_offs   = ^{offs[31:19], offs[1:0]};

    always_comb begin
        rdata            = '0;
        ready            = 1'b0;
        cache_write_data = '0;
        cache_read_en    = 1'b0;
        cache_write_en   = 1'b0;
        cache_inv_en     = 1'b0;
        sram_r_en        = 1'b0;
        sram_w_en        = 1'b0;
        sram_address     = '0;
        sram_wdata       = '0;
        case (state)
            IDLE: begin
                // A simultaneous read+write is handled as a store.
                if (mem_w_en) begin
                    cache_inv_en = 1'b1;
                end else if (mem_r_en) begin
                    if (cache_hit) begin
                        ready         = 1'b1;
                        rdata         = cache_read_data;
                        cache_read_en = 1'b1;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            RD_MISS: begin
                sram_r_en    = 1'b1;
                sram_address = line_addr;
                if (sram_ready) begin
                    cache_write_en   = 1'b1;
                    cache_write_data = sram_rdata;
                    rdata            = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
                    ready            = 1'b1;
                end
            end
            WR: begin
                sram_w_en    = 1'b1;
                sram_address = wr_addr;
                sram_wdata   = wr_data;
                ready        = sram_ready;
            end
            default: ;
        endcase
        // Nothing may strobe the cache or SRAM while reset is held.
        if (!rst) begin
            cache_read_en  = 1'b0;
            cache_write_en = 1'b0;
            cache_inv_en   = 1'b0;
            sram_r_en      = 1'b0;
            sram_w_en      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            line_addr  <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            word_sel   <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_w_en) begin
                        wr_addr <= address;
                        wr_data <= wdata;
                        state   <= WR;
                    end else if (mem_r_en) begin
                        if (cache_hit) begin
                            if (hit_count != '1) hit_count <= hit_count + 1'b1;
                        end else begin
                            if (miss_count != '1) miss_count <= miss_count + 1'b1;
                            line_addr <= {address[31:3], 3'b000};
                            word_sel  <= offs[2];
                            state     <= RD_MISS;
                        end
                    end
                end
                RD_MISS: if (sram_ready) state <= IDLE;
                WR:      if (sram_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_controller.sv
// Random and directed load/store traffic against a word-level memory model with a cached-line set.
// A simple cache array and SRAM stub act as the environment around the controller.
module tb_cache_controller;
    localparam int          PW   = 4;
    localparam logic [31:0] BASE = 32'd1024;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_r_en = 1'b0, mem_w_en = 1'b0;
    logic [31:0]   address = BASE, wdata = '0;
    logic [31:0]   rdata;
    logic          ready;
    logic [16:0]   cache_address;
    logic [63:0]   cache_write_data;
    logic          cache_read_en, cache_write_en, cache_inv_en;
    logic [31:0]   cache_read_data;
    logic          cache_hit;
    logic          sram_r_en, sram_w_en;
    logic [31:0]   sram_address, sram_wdata;
    logic [63:0]   sram_rdata = '0;
    logic          sram_ready = 1'b0;
    logic [PW-1:0] hit_count, miss_count;

    cache_controller #(.BASE_ADDR(1024), .PERF_W(PW)) dut (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
        .cache_address(cache_address), .cache_write_data(cache_write_data),
        .cache_read_en(cache_read_en), .cache_write_en(cache_write_en),
        .cache_inv_en(cache_inv_en), .cache_read_data(cache_read_data),
        .cache_hit(cache_hit), .sram_r_en(sram_r_en), .sram_w_en(sram_w_en),
        .sram_address(sram_address), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Environment: cache line store indexed by line number, SRAM word store.
    logic [63:0] cdata  [0:2047];
    logic        cvalid [0:2047];
    logic [31:0] sram_mem [0:4095];

    assign cache_hit       = cvalid[cache_address[11:1]];
    assign cache_read_data = cache_address[0] ? cdata[cache_address[11:1]][63:32]
                                              : cdata[cache_address[11:1]][31:0];

    always @(posedge clk) begin
        if (cache_write_en) begin
            cdata[cache_address[11:1]]  <= cache_write_data;
            cvalid[cache_address[11:1]] <= 1'b1;
        end
        if (cache_inv_en) cvalid[cache_address[11:1]] <= 1'b0;
    end

    // Reference model: architectural memory, set of cached lines, counters.
    logic [31:0] ref_mem [0:4095];
    bit          ref_cached [0:2047];
    int          ref_hits = 0, ref_misses = 0;
    int          errs = 0, checks = 0;
    localparam int SAT = (1 << PW) - 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // op: 0 load, 1 store, 2 load+store. wt: SRAM wait cycles before sram_ready.
    task automatic xact(input int op, input logic [31:0] a, input logic [31:0] d,
                        input int wt, input bit drop);
        int          w, ln, nlow, nbusy;
        bit          hit, done;
        logic [31:0] exp_rd, line_a, si;
        w      = int'((a - BASE) >> 2);
        ln     = w >> 1;
        line_a = {a[31:3], 3'b000};
        hit    = (op == 0) && ref_cached[ln];
        exp_rd = ref_mem[w];
        mem_r_en = (op != 1);
        mem_w_en = (op != 0);
        address  = a;
        wdata    = d;
        nlow = 0; nbusy = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (sram_r_en || sram_w_en) begin
                if (nbusy == wt) begin
                    si = (sram_address - BASE) >> 2;
                    sram_ready = 1'b1;
                    sram_rdata = {sram_mem[{si[11:1], 1'b1}], sram_mem[{si[11:1], 1'b0}]};
                    if (sram_w_en) sram_mem[si[11:0]] = sram_wdata;
                end
                nbusy++;
            end
            #1;
            if (c == 0) begin
                chk("cache_addr", 64'(cache_address), 64'(w));
                chk("inv_en", 64'(cache_inv_en), 64'(op != 0));
                chk("read_en", 64'(cache_read_en), 64'(hit));
            end
            if (sram_r_en || sram_w_en) begin
                chk("sram_addr", 64'(sram_address), 64'(op == 0 ? line_a : a));
                chk("sram_r_en", 64'(sram_r_en), 64'(op == 0));
                if (op != 0) chk("sram_wdata", 64'(sram_wdata), 64'(d));
            end
            if (ready) begin
                done = 1;
                if (op == 0 && !drop) chk("rdata", 64'(rdata), 64'(exp_rd));
                chk("fill_en", 64'(cache_write_en), 64'(op == 0 && !hit));
            end else begin
                nlow++;
            end
            @(posedge clk);
            #1;
            sram_ready = 1'b0;
            if (drop) begin mem_r_en = 1'b0; mem_w_en = 1'b0; end
        end
        chk("completed", 64'(done), 64'd1);
        chk("stall_cycles", 64'(nlow), 64'(hit ? 0 : 1 + wt));
        if (op == 0) begin
            if (hit) ref_hits = (ref_hits == SAT) ? SAT : ref_hits + 1;
            else begin
                ref_misses     = (ref_misses == SAT) ? SAT : ref_misses + 1;
                ref_cached[ln] = 1;
            end
        end else begin
            ref_mem[w]     = d;
            ref_cached[ln] = 0;
        end
        chk("hit_count", 64'(hit_count), 64'(ref_hits));
        chk("miss_count", 64'(miss_count), 64'(ref_misses));
    endtask

    task automatic go_idle();
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 4096; i++) begin
            v = $urandom;
            sram_mem[i] = v;
            ref_mem[i]  = v;
        end
        for (int i = 0; i < 2048; i++) begin
            cvalid[i]     = 1'b0;
            ref_cached[i] = 0;
        end
        sram_mem[2] = 32'hAAAA_0000; ref_mem[2] = 32'hAAAA_0000;
        sram_mem[3] = 32'hBBBB_0000; ref_mem[3] = 32'hBBBB_0000;

        // Reset state
        #12;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_strobes", 64'({cache_read_en, cache_write_en, cache_inv_en, sram_r_en, sram_w_en}), 64'd0);
        chk("rst_hits", 64'(hit_count), 64'd0);
        chk("rst_misses", 64'(miss_count), 64'd0);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;

        // Miss, hit on both words, store then miss again
        xact(0, 32'd1032, '0, 2, 0);
        xact(0, 32'd1032, '0, 0, 0);
        xact(0, 32'd1036, '0, 0, 0);
        xact(1, 32'd1032, 32'h1234_5678, 1, 0);
        xact(0, 32'd1032, '0, 0, 0);
        // Long SRAM wait: five stall cycles
        xact(0, 32'd1100, '0, 4, 0);
        // Read+write together takes the store path
        xact(2, 32'd1040, 32'hCAFE_F00D, 0, 0);
        xact(0, 32'd1040, '0, 1, 0);
        // Dropped requests still complete
        xact(0, 32'd1200, '0, 2, 1);
        xact(0, 32'd1200, '0, 0, 0);
        xact(1, 32'd1204, 32'h0BAD_BEEF, 2, 1);
        go_idle();
        @(posedge clk); #1;

        for (int n = 0; n < 150; n++) begin
            int wi;
            int op;
            wi = $urandom_range(0, 127);
            op = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 2);
            xact(op, BASE + 32'(wi * 4), $urandom, $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 4) == 0) begin go_idle(); @(posedge clk); #1; end
        end
        go_idle();
        @(posedge clk); #1;

        // Reset in the middle of a miss: no fill, counters cleared
        xact(1, 32'd1300, 32'h5555_AAAA, 0, 0);
        go_idle();
        @(posedge clk); #1;
        mem_r_en = 1'b1; address = 32'd1300;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_sram_r", 64'(sram_r_en), 64'd1);
        rst = 1'b0;
        sram_ready = 1'b1;
        #1;
        chk("mid_rst_sram_r", 64'(sram_r_en), 64'd0);
        chk("mid_rst_fill", 64'(cache_write_en), 64'd0);
        chk("mid_rst_hits", 64'(hit_count), 64'd0);
        chk("mid_rst_misses", 64'(miss_count), 64'd0);
        @(posedge clk); #1;
        sram_ready = 1'b0;
        go_idle();
        rst = 1'b1;
        ref_hits = 0; ref_misses = 0;
        @(posedge clk); #1;
        xact(0, 32'd1300, '0, 1, 0);

        // Hit counter saturation
        for (int i = 0; i < (1 << PW) + 3; i++) xact(0, 32'd1300, '0, 0, 0);
        chk("hit_sat", 64'(hit_count), 64'(SAT));
        go_idle();
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
